// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped serial output port: default addresses,
// transmitter state encoding and the status-word layout.
package io_pkg;

    localparam logic [15:0] IO_ADDR_DEFAULT     = 16'hFFF0;
    localparam logic [15:0] STATUS_ADDR_DEFAULT = 16'hFFF1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_COUNT_LSB = 8;

    // Status word: queued-entry count in the high byte, flags in the low bits.
    function automatic logic [15:0] build_status(input logic [7:0] count,
                                                 input logic       busy,
                                                 input logic       full,
                                                 input logic       empty);
        logic [15:0] status;
        status                            = '0;
        status[STAT_COUNT_LSB +: 8]       = count;
        status[STAT_BUSY_BIT]             = busy;
        status[STAT_FULL_BIT]             = full;
        status[STAT_EMPTY_BIT]            = empty;
        return status;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy; full/empty come from
// the registered count so a same-cycle pop never frees a slot for a same-cycle push.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/io_tx_port.sv
// CPU-store-driven 8N1 serial transmitter: stores to IO_ADDR queue into a FIFO,
// the low byte of each entry is framed onto o_TX, and a full FIFO stalls the CPU.
module io_tx_port
    import io_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [15:0] IO_ADDR      = IO_ADDR_DEFAULT,
    parameter logic [15:0] STATUS_ADDR  = STATUS_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        i_RESET,
    input  logic        i_WRITE,
    input  logic [15:0] i_WADDR,
    input  logic [15:0] i_WDATA,
    input  logic [15:0] i_RADDR,
    output logic [15:0] o_RDATA,
    output logic        o_RHIT,
    output logic        o_IOPAUSE,
    output logic        o_TX
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    logic             whit;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [15:0]      fifo_data;
    logic [7:0]       unused_hi_bits;

    tx_state_t        state;
    tx_state_t        state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             tx_reg;
    logic             tx_next;
    logic             baud_last;

    assign whit      = i_WRITE && (i_WADDR == IO_ADDR);
    assign o_IOPAUSE = whit && full;
    assign pop       = (state == IDLE) && !empty;
    assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    // Only the low byte is transmitted; the upper byte is stored but never used.
    assign unused_hi_bits = fifo_data[15:8];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset   (i_RESET),
        .push    (whit),
        .pop     (pop),
        .wr_data (i_WDATA),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (i_RESET) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            tx_reg   <= tx_next;
        end
    end

    // The line level is computed from the state being entered, so o_TX changes on
    // the same edge as the state and comes straight from a flop.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        tx_next    = 1'b1;

        case (state)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (!empty) begin
                    shreg_next = fifo_data[7:0];
                    state_next = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shreg_next = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign o_TX    = tx_reg;
    assign o_RHIT  = (i_RADDR == STATUS_ADDR);
    assign o_RDATA = o_RHIT ? build_status(8'(count), state != IDLE, full, empty) : 16'h0000;

endmodule

// File: tb/tb_io_tx_port.sv
// Randomised bench for io_tx_port: a queue-and-timeline model predicts every output each
// cycle, and a short directed prologue pins frame shape, stall and status values to literals.
module tb_io_tx_port;

    localparam int          DEPTH  = 8;
    localparam int          CPB    = 4;
    localparam logic [15:0] IO_A   = 16'hFFF0;
    localparam logic [15:0] STAT_A = 16'hFFF1;

    logic        clk = 1'b0;
    logic        i_RESET;
    logic        i_WRITE;
    logic [15:0] i_WADDR;
    logic [15:0] i_WDATA;
    logic [15:0] i_RADDR;
    logic [15:0] o_RDATA;
    logic        o_RHIT;
    logic        o_IOPAUSE;
    logic        o_TX;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: queued words, and the running frame as (byte, cycles since its start).
    logic [15:0] mq[$];
    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [7:0]  m_byte = 8'h00;
    bit          m_pause = 1'b0;

    io_tx_port #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB),
        .IO_ADDR      (IO_A),
        .STATUS_ADDR  (STAT_A)
    ) dut (
        .clk       (clk),
        .i_RESET   (i_RESET),
        .i_WRITE   (i_WRITE),
        .i_WADDR   (i_WADDR),
        .i_WDATA   (i_WDATA),
        .i_RADDR   (i_RADDR),
        .o_RDATA   (o_RDATA),
        .o_RHIT    (o_RHIT),
        .o_IOPAUSE (o_IOPAUSE),
        .o_TX      (o_TX)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic wr, input logic [15:0] waddr, input logic [15:0] wdata,
                                  input logic [15:0] raddr, input logic rst);
        i_WRITE = wr;
        i_WADDR = waddr;
        i_WDATA = wdata;
        i_RADDR = raddr;
        i_RESET = rst;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic model_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_t / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_byte[idx - 1];
    endfunction

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        int n;
        n = mq.size();
        s = '0;
        s[15:8] = 8'(n);
        s[2] = m_active;
        s[1] = (n == DEPTH);
        s[0] = (n == 0);
        return s;
    endfunction

    // Model advances on each edge using the inputs the DUT sees on that edge.
    always @(posedge clk) begin
        bit          whit;
        bit          do_pop;
        bit          do_push;
        int          n;
        logic [15:0] head;
        whit = (i_WRITE === 1'b1) && (i_WADDR == IO_A);
        n    = mq.size();
        if (i_RESET === 1'b1) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            do_pop  = !m_active && (n != 0);
            do_push = whit && (n < DEPTH);
            if (m_active) begin
                m_t++;
                if (m_t == 10 * CPB) m_active = 1'b0;
            end
            if (do_pop) begin
                head     = mq.pop_front();
                m_byte   = head[7:0];
                m_active = 1'b1;
                m_t      = 0;
            end
            if (do_push) mq.push_back(i_WDATA);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit          whit;
        bit          rhit;
        logic [15:0] exp_rdata;
        whit      = (i_WRITE === 1'b1) && (i_WADDR == IO_A);
        rhit      = (i_RADDR == STAT_A);
        m_pause   = whit && (mq.size() == DEPTH);
        exp_rdata = rhit ? model_status() : 16'h0000;
        if (chk_en) begin
            check_output("tx", 16'(o_TX), 16'(model_tx()));
            check_output("iopause", 16'(o_IOPAUSE), 16'(m_pause));
            check_output("rhit", 16'(o_RHIT), 16'(rhit));
            check_output("rdata", o_RDATA, exp_rdata);
        end
    end

    initial begin
        logic [9:0] frame_bits;
        int         waited;
        int         rate;
        int         r;
        logic [15:0] addr;

        frame_bits = 10'b1010101010;
        apply_stimulus(1'b0, 16'h0000, 16'h0000, STAT_A, 1'b1);

        // Reset for one edge, then idle.
        @(posedge clk);
        #1;
        chk_en  = 1'b1;
        i_RESET = 1'b0;
        step();
        check_output("reset_status", o_RDATA, 16'h0001);
        check_output("reset_rhit", 16'(o_RHIT), 16'h0001);
        check_output("reset_tx", 16'(o_TX), 16'h0001);
        check_output("reset_pause", 16'(o_IOPAUSE), 16'h0000);

        // Single frame carrying 0x55.
        apply_stimulus(1'b1, IO_A, 16'h1255, STAT_A, 1'b0);
        step();
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b0);
        for (int i = 0; i < 10 * CPB; i++) begin
            step();
            check_output($sformatf("frame55_c%0d", i), 16'(o_TX), 16'(frame_bits[i / CPB]));
        end
        step();
        check_output("frame55_idle_tx", 16'(o_TX), 16'h0001);
        check_output("frame55_idle_status", o_RDATA, 16'h0001);

        // Stores to neighbouring addresses are ignored.
        apply_stimulus(1'b1, 16'hFFEF, 16'hA5A5, STAT_A, 1'b0);
        step();
        apply_stimulus(1'b1, STAT_A, 16'h5A5A, STAT_A, 1'b0);
        step();
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b0);
        step();
        check_output("ignored_status", o_RDATA, 16'h0001);
        check_output("ignored_tx", 16'(o_TX), 16'h0001);

        // Three queued behind an active frame, then fill to eight, then stall the ninth.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, IO_A, 16'h0030 + 16'(i), STAT_A, 1'b0);
            step();
        end
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b0);
        check_output("status_3q", o_RDATA, 16'h0304);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, IO_A, 16'h0040 + 16'(i), STAT_A, 1'b0);
            step();
        end
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b0);
        check_output("status_8q", o_RDATA, 16'h0806);
        apply_stimulus(1'b1, IO_A, 16'h00AA, STAT_A, 1'b0);
        #1;
        check_output("pause_on_full", 16'(o_IOPAUSE), 16'h0001);
        waited = 0;
        while (o_IOPAUSE === 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        check_output("stall_released", 16'(waited < 100), 16'h0001);
        step();
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b0);
        check_output("status_refill", o_RDATA, 16'h0806);

        // Reset mid-frame (DATA bit 3) with five queued.
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b1);
        step();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, IO_A, 16'h00F0 + 16'(i), STAT_A, 1'b0);
            step();
        end
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b0);
        check_output("pre_reset_status", o_RDATA, 16'h0504);
        for (int i = 0; i < 13; i++) step();
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b1);
        step();
        apply_stimulus(1'b0, IO_A, 16'h0000, STAT_A, 1'b0);
        check_output("midframe_reset_tx", 16'(o_TX), 16'h0001);
        check_output("midframe_reset_status", o_RDATA, 16'h0001);
        for (int i = 0; i < 60; i++) begin
            step();
            check_output("post_reset_quiet", 16'(o_TX), 16'h0001);
        end

        // Random traffic; the CPU holds its store while paused.
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) rate = (c % 1000 == 0) ? 40 : 3;
            if (!m_pause) begin
                r = int'($urandom_range(0, 99));
                case ($urandom_range(0, 3))
                    0:       addr = 16'hFFEF;
                    1:       addr = STAT_A;
                    default: addr = IO_A;
                endcase
                apply_stimulus(1'b0, addr, 16'($urandom()), 16'($urandom()), 1'b0);
                if (r < rate) begin
                    i_WRITE = 1'b1;
                    i_WADDR = IO_A;
                end else if (r < rate + 5) begin
                    i_WRITE = 1'b1;
                end
                if ($urandom_range(0, 1) == 0) i_RADDR = STAT_A;
                if ($urandom_range(0, 999) < 3) i_RESET = 1'b1;
            end
            step();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
